// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one full-subtractor cell iterated LSB-first over WIDTH cycles.
// Computes diff = a - b - bin with borrow-out and signed overflow, using a start/busy/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned RES_W = WIDTH - 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_br;
  logic [RES_W-1:0]   r_res;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;
  logic               r_overflow;

  state_e             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]   w_a_nxt;
  logic [WIDTH-1:0]   w_b_nxt;
  logic               w_br_nxt;
  logic [RES_W-1:0]   w_res_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic [WIDTH-1:0]   w_diff_nxt;
  logic               w_borrow_nxt;
  logic               w_overflow_nxt;

  logic               w_d;
  logic               w_br_cell;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_full;

  // Full-subtractor cell on the current LSBs of the shifting operand registers.
  assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_cell  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_res_full = {w_d, r_res};

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_br_nxt       = r_br;
    w_res_nxt      = r_res;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_diff_nxt     = r_diff;
    w_borrow_nxt   = r_borrow;
    w_overflow_nxt = r_overflow;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_br_nxt    = bin;
          w_res_nxt   = '0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_a_nxt   = r_a >> 1;
        w_b_nxt   = r_b >> 1;
        w_br_nxt  = w_br_cell;
        w_res_nxt = w_res_full[WIDTH-1:1];
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // On the last bit r_a[0]/r_b[0] hold the latched operand sign bits.
        if (w_last) begin
          w_diff_nxt     = w_res_full;
          w_borrow_nxt   = w_br_cell;
          w_overflow_nxt = (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
          w_done_nxt     = 1'b1;
          w_busy_nxt     = 1'b0;
          w_cnt_nxt      = '0;
          w_state_nxt    = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_br       <= 1'b0;
      r_res      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_diff     <= '0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_br       <= w_br_nxt;
      r_res      <= w_res_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_diff     <= w_diff_nxt;
      r_borrow   <= w_borrow_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign diff     = r_diff;
  assign borrow   = r_borrow;
  assign overflow = r_overflow;

  a_done_not_busy: assert property (@(posedge clk) disable iff (rst) r_done |-> !r_busy);
  a_busy_is_run:   assert property (@(posedge clk) disable iff (rst) r_busy == (r_state == S_RUN));
  a_cnt_in_range:  assert property (@(posedge clk) disable iff (rst) r_cnt < CNT_W'(WIDTH));

endmodule
